// File: rtl/siu_l2_trk_pkg.sv
// siu_l2_trk_pkg
//   Shared types and helpers for the SIU->L2 request tracker.
//   - trk_state_e : per-bank sequencing FSM state (IDLE, HDR, GAP)
//   - *_DEF       : default header/dummy cycle counts and WRI marker bit
//   - sat_updn    : saturating up/down counter step
package siu_l2_trk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        GAP  = 2'd2
    } trk_state_e;

    localparam int HDR_CYC_DEF   = 2;
    localparam int DUMMY_CYC_DEF = 3;
    localparam int WRI_BIT_DEF   = 29;

    // One counter step: inc and dec together cancel; the count clamps at
    // 0 on the way down and at max on the way up.
    function automatic int unsigned sat_updn(input int unsigned cnt,
                                             input logic        inc,
                                             input logic        dec,
                                             input int unsigned max);
        if (inc && !dec)
            return (cnt >= max) ? max : cnt + 1;
        else if (dec && !inc)
            return (cnt == 0) ? 0 : cnt - 1;
        return cnt;
    endfunction

endpackage

// File: rtl/siu_l2_trk_bank.sv
// siu_l2_trk_bank
//   Passive monitor for one L2 bank: request sequencing FSM, header capture,
//   IQ/WIB occupancy counters and sticky protocol error flags.
//   Optional macro SIU_L2_TRK_STATS_EN adds saturating request totals.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mon_en            tracking enable (gates new requests and error setting)
//   req, req_vld      request word / valid from the SII
//   iq_dequeue        IQ entry released by the L2T
//   wib_dequeue       WIB entry drained by the L2T
//   hdr_vld, hdr_data one-cycle header pulse and held header (word 0 low)
//   iq_cnt, wib_cnt   outstanding IQ / WRI entries
//   err_*             sticky error flags
//   req_total, wri_total  (stats build only) header counts
module siu_l2_trk_bank
    import siu_l2_trk_pkg::*;
#(
    parameter int REQ_W     = 32,
    parameter int HDR_CYC   = HDR_CYC_DEF,
    parameter int DUMMY_CYC = DUMMY_CYC_DEF,
    parameter int IQ_DEPTH  = 16,
    parameter int WIB_DEPTH = 8,
    parameter int WRI_BIT   = WRI_BIT_DEF,
    parameter int CNT_W     = $clog2(IQ_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mon_en,
    input  logic [REQ_W-1:0]           req,
    input  logic                       req_vld,
    input  logic                       iq_dequeue,
    input  logic                       wib_dequeue,
    output logic                       hdr_vld,
    output logic [HDR_CYC*REQ_W-1:0]   hdr_data,
    output logic [CNT_W-1:0]           iq_cnt,
    output logic [CNT_W-1:0]           wib_cnt,
    output logic                       err_overlap,
    output logic                       err_iq_uflow,
    output logic                       err_iq_oflow,
    output logic                       err_wib_uflow
`ifdef SIU_L2_TRK_STATS_EN
   ,output logic [15:0]                req_total,
    output logic [15:0]                wri_total
`endif
);

    // One counter serves both the header word index and the dummy cycles.
    localparam int SEQ_MAX = (HDR_CYC > DUMMY_CYC) ? HDR_CYC : DUMMY_CYC;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

    trk_state_e                     state, state_nxt;
    logic [SEQ_W-1:0]               seq, seq_nxt;
    logic [HDR_CYC-1:0][REQ_W-1:0]  hdr_buf, hdr_buf_nxt;
    logic                           hdr_done;
    logic                           iq_inc, wib_inc;

    // Counters act on the registered pulse so hdr_data is already stable
    // when the WRI bit is examined.
    assign iq_inc  = hdr_vld;
    assign wib_inc = hdr_vld && hdr_data[WRI_BIT];

    always_comb begin
        state_nxt   = state;
        seq_nxt     = seq;
        hdr_buf_nxt = hdr_buf;
        hdr_done    = 1'b0;
        case (state)
            IDLE: begin
                if (req_vld && mon_en) begin
                    state_nxt = HDR;
                    seq_nxt   = '0;
                end
            end
            HDR: begin
                for (int i = 0; i < HDR_CYC; i++)
                    if (seq == SEQ_W'(i)) hdr_buf_nxt[i] = req;
                if (seq == SEQ_W'(HDR_CYC - 1)) begin
                    hdr_done  = 1'b1;
                    state_nxt = GAP;
                    seq_nxt   = '0;
                end else begin
                    seq_nxt = seq + SEQ_W'(1);
                end
            end
            GAP: begin
                if (seq == SEQ_W'(DUMMY_CYC - 1)) begin
                    state_nxt = IDLE;
                    seq_nxt   = '0;
                end else begin
                    seq_nxt = seq + SEQ_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                seq_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            seq           <= '0;
            hdr_buf       <= '0;
            hdr_vld       <= 1'b0;
            hdr_data      <= '0;
            iq_cnt        <= '0;
            wib_cnt       <= '0;
            err_overlap   <= 1'b0;
            err_iq_uflow  <= 1'b0;
            err_iq_oflow  <= 1'b0;
            err_wib_uflow <= 1'b0;
        end else begin
            state   <= state_nxt;
            seq     <= seq_nxt;
            hdr_buf <= hdr_buf_nxt;
            hdr_vld <= hdr_done;
            if (hdr_done) hdr_data <= hdr_buf_nxt;

            iq_cnt  <= CNT_W'(sat_updn(32'(iq_cnt), iq_inc, iq_dequeue, IQ_DEPTH));
            wib_cnt <= CNT_W'(sat_updn(32'(wib_cnt), wib_inc, wib_dequeue, WIB_DEPTH));

            // A request while busy is only flagged; the sequence in flight
            // carries on untouched.
            if (mon_en) begin
                if (req_vld && state != IDLE)                          err_overlap   <= 1'b1;
                if (iq_dequeue && !iq_inc && iq_cnt == '0)             err_iq_uflow  <= 1'b1;
                if (iq_inc && !iq_dequeue && iq_cnt == CNT_W'(IQ_DEPTH)) err_iq_oflow <= 1'b1;
                if (wib_dequeue && !wib_inc && wib_cnt == '0)          err_wib_uflow <= 1'b1;
            end
        end
    end

`ifdef SIU_L2_TRK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            req_total <= '0;
            wri_total <= '0;
        end else begin
            if (iq_inc && req_total != 16'hFFFF)  req_total <= req_total + 16'd1;
            if (wib_inc && wri_total != 16'hFFFF) wri_total <= wri_total + 16'd1;
        end
    end
`endif

endmodule

// File: rtl/siu_l2_req_tracker.sv
// siu_l2_req_tracker
//   Passive SII->L2T inbound request tracker across N_BANKS banks. Each bank
//   is an independent siu_l2_trk_bank; this level only slices flat buses.
//   Optional macro SIU_L2_TRK_STATS_EN adds req_total / wri_total outputs.
// Ports:
//   iol2clk, rst                  clock, synchronous active-high reset
//   mon_en                        tracking enable
//   sii_l2t_req, sii_l2t_req_vld  request words / valids, bank b at slice b
//   l2t_sii_iq_dequeue            IQ dequeue per bank
//   l2t_sii_wib_dequeue           WIB drain per bank
//   hdr_vld, hdr_data             header pulse / held header per bank
//   iq_cnt, wib_cnt               occupancy per bank (CNT_W each)
//   err_overlap, err_iq_uflow, err_iq_oflow, err_wib_uflow  sticky errors
module siu_l2_req_tracker
    import siu_l2_trk_pkg::*;
#(
    parameter int N_BANKS   = 8,
    parameter int REQ_W     = 32,
    parameter int HDR_CYC   = HDR_CYC_DEF,
    parameter int DUMMY_CYC = DUMMY_CYC_DEF,
    parameter int IQ_DEPTH  = 16,
    parameter int WIB_DEPTH = 8,
    parameter int WRI_BIT   = WRI_BIT_DEF,
    parameter int CNT_W     = $clog2(IQ_DEPTH + 1)
) (
    input  logic                               iol2clk,
    input  logic                               rst,
    input  logic                               mon_en,
    input  logic [N_BANKS*REQ_W-1:0]           sii_l2t_req,
    input  logic [N_BANKS-1:0]                 sii_l2t_req_vld,
    input  logic [N_BANKS-1:0]                 l2t_sii_iq_dequeue,
    input  logic [N_BANKS-1:0]                 l2t_sii_wib_dequeue,
    output logic [N_BANKS-1:0]                 hdr_vld,
    output logic [N_BANKS*HDR_CYC*REQ_W-1:0]   hdr_data,
    output logic [N_BANKS*CNT_W-1:0]           iq_cnt,
    output logic [N_BANKS*CNT_W-1:0]           wib_cnt,
    output logic [N_BANKS-1:0]                 err_overlap,
    output logic [N_BANKS-1:0]                 err_iq_uflow,
    output logic [N_BANKS-1:0]                 err_iq_oflow,
    output logic [N_BANKS-1:0]                 err_wib_uflow
`ifdef SIU_L2_TRK_STATS_EN
   ,output logic [N_BANKS*16-1:0]              req_total,
    output logic [N_BANKS*16-1:0]              wri_total
`endif
);

    localparam int HW = HDR_CYC * REQ_W;

    for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
        siu_l2_trk_bank #(
            .REQ_W     (REQ_W),
            .HDR_CYC   (HDR_CYC),
            .DUMMY_CYC (DUMMY_CYC),
            .IQ_DEPTH  (IQ_DEPTH),
            .WIB_DEPTH (WIB_DEPTH),
            .WRI_BIT   (WRI_BIT),
            .CNT_W     (CNT_W)
        ) u_bank (
            .clk           (iol2clk),
            .rst           (rst),
            .mon_en        (mon_en),
            .req           (sii_l2t_req[g*REQ_W +: REQ_W]),
            .req_vld       (sii_l2t_req_vld[g]),
            .iq_dequeue    (l2t_sii_iq_dequeue[g]),
            .wib_dequeue   (l2t_sii_wib_dequeue[g]),
            .hdr_vld       (hdr_vld[g]),
            .hdr_data      (hdr_data[g*HW +: HW]),
            .iq_cnt        (iq_cnt[g*CNT_W +: CNT_W]),
            .wib_cnt       (wib_cnt[g*CNT_W +: CNT_W]),
            .err_overlap   (err_overlap[g]),
            .err_iq_uflow  (err_iq_uflow[g]),
            .err_iq_oflow  (err_iq_oflow[g]),
            .err_wib_uflow (err_wib_uflow[g])
`ifdef SIU_L2_TRK_STATS_EN
           ,.req_total     (req_total[g*16 +: 16]),
            .wri_total     (wri_total[g*16 +: 16])
`endif
        );
    end

endmodule

// File: tb/tb_siu_l2_req_tracker.sv
// tb_siu_l2_req_tracker
//   Directed bench for siu_l2_req_tracker. Expected headers are queued when a
//   request is driven and matched by a negedge monitor on every hdr_vld pulse;
//   counters and error flags are checked at fixed points in the sequence.
//   Define SIU_L2_TRK_STATS_EN to also exercise req_total / wri_total.
module tb_siu_l2_req_tracker;

    localparam int NB = 8;
    localparam int RW = 32;
    localparam int HC = 2;
    localparam int HW = HC * RW;
    localparam int CW = 5;

    logic              iol2clk = 1'b0;
    logic              rst;
    logic              mon_en;
    logic [NB*RW-1:0]  req;
    logic [NB-1:0]     req_vld;
    logic [NB-1:0]     iq_dq;
    logic [NB-1:0]     wib_dq;
    logic [NB-1:0]     hdr_vld;
    logic [NB*HW-1:0]  hdr_data;
    logic [NB*CW-1:0]  iq_cnt;
    logic [NB*CW-1:0]  wib_cnt;
    logic [NB-1:0]     err_overlap, err_iq_uflow, err_iq_oflow, err_wib_uflow;
`ifdef SIU_L2_TRK_STATS_EN
    logic [NB*16-1:0]  req_total, wri_total;
`endif

    siu_l2_req_tracker dut (
        .iol2clk             (iol2clk),
        .rst                 (rst),
        .mon_en              (mon_en),
        .sii_l2t_req         (req),
        .sii_l2t_req_vld     (req_vld),
        .l2t_sii_iq_dequeue  (iq_dq),
        .l2t_sii_wib_dequeue (wib_dq),
        .hdr_vld             (hdr_vld),
        .hdr_data            (hdr_data),
        .iq_cnt              (iq_cnt),
        .wib_cnt             (wib_cnt),
        .err_overlap         (err_overlap),
        .err_iq_uflow        (err_iq_uflow),
        .err_iq_oflow        (err_iq_oflow),
        .err_wib_uflow       (err_wib_uflow)
`ifdef SIU_L2_TRK_STATS_EN
       ,.req_total           (req_total),
        .wri_total           (wri_total)
`endif
    );

    always #5 iol2clk = ~iol2clk;

    typedef struct {
        int              bank;
        logic [HW-1:0]   data;
    } exp_t;

    exp_t exp_q[$];
    int   hdr_seen[NB];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [CW-1:0] iq_of(input int b);
        return iq_cnt[b*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] wib_of(input int b);
        return wib_cnt[b*CW +: CW];
    endfunction

    function automatic logic [NB*RW-1:0] put(input int b, input logic [RW-1:0] w);
        logic [NB*RW-1:0] v;
        v = '0;
        v[b*RW +: RW] = w;
        return v;
    endfunction

    task automatic tick();
        @(posedge iol2clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Drive valid then the HDR_CYC header words. Returns one step after the
    // edge that captured the last word, i.e. while hdr_vld is high.
    task automatic send(input logic [NB-1:0] mask, input logic [NB*RW-1:0] w0,
                        input logic [NB*RW-1:0] w1);
        exp_t e;
        if (mon_en)
            for (int b = 0; b < NB; b++)
                if (mask[b]) begin
                    e.bank = b;
                    e.data = {w1[b*RW +: RW], w0[b*RW +: RW]};
                    exp_q.push_back(e);
                end
        req_vld = mask;
        tick();
        req_vld = '0;
        req = w0;
        tick();
        req = w1;
        tick();
        req = '0;
    endtask

    // Scoreboard monitor: every header pulse must match the oldest queued
    // header of that bank.
    always @(negedge iol2clk) begin
        if (!rst) begin
            for (int b = 0; b < NB; b++) begin
                if (hdr_vld[b]) begin : mon_b
                    int idx;
                    idx = -1;
                    hdr_seen[b]++;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (idx < 0 && exp_q[i].bank == b) idx = i;
                    if (idx < 0)
                        chk($sformatf("hdr_unexpected_b%0d", b), 64'(hdr_vld[b]), 64'd0);
                    else begin
                        chk($sformatf("hdr_data_b%0d", b), hdr_data[b*HW +: HW], exp_q[idx].data);
                        exp_q.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1, "timeout");
    end

    initial begin
        logic [NB*RW-1:0] w0v, w1v;
        for (int b = 0; b < NB; b++) hdr_seen[b] = 0;
        rst = 1'b1; mon_en = 1'b0;
        req = '0; req_vld = '0; iq_dq = '0; wib_dq = '0;
        idle(3);

        // Reset state
        chk("rst_hdr_vld", 64'(hdr_vld), 64'd0);
        chk("rst_hdr_data", 64'(|hdr_data), 64'd0);
        chk("rst_iq_cnt", 64'(iq_cnt), 64'd0);
        chk("rst_wib_cnt", 64'(wib_cnt), 64'd0);
        chk("rst_errs", 64'({err_overlap, err_iq_uflow, err_iq_oflow, err_wib_uflow}), 64'd0);

        rst = 1'b0; mon_en = 1'b1;
        idle(2);

        // Bank 0: plain request (bit 29 of word 0 clear, so not a WRI)
        send(8'h01, put(0, 32'h8000_0001), put(0, 32'h0000_BEEF));
        chk("b0_hdr_vld", 64'(hdr_vld), 64'h01);
        chk("b0_hdr_data", hdr_data[HW-1:0], 64'h0000_BEEF_8000_0001);
        tick();
        chk("b0_hdr_vld_pulse", 64'(hdr_vld), 64'h00);
        chk("b0_iq", 64'(iq_of(0)), 64'd1);
        chk("b0_wib", 64'(wib_of(0)), 64'd0);
        idle(2);

        // Bank 3: WRI request, then one IQ and one WIB dequeue together
        send(8'h08, put(3, 32'h2000_0003), put(3, 32'h1234_5678));
        tick();
        chk("b3_iq_up", 64'(iq_of(3)), 64'd1);
        chk("b3_wib_up", 64'(wib_of(3)), 64'd1);
        idle(2);
        iq_dq = 8'h08; wib_dq = 8'h08;
        tick();
        iq_dq = '0; wib_dq = '0;
        chk("b3_iq_down", 64'(iq_of(3)), 64'd0);
        chk("b3_wib_down", 64'(wib_of(3)), 64'd0);
        chk("b3_no_errs", 64'({err_overlap, err_iq_uflow, err_iq_oflow, err_wib_uflow}), 64'd0);

        // Bank 5: second valid at T+3 lands in GAP; next one at T+6 is clean
        send(8'h20, put(5, 32'h0000_0055), put(5, 32'h5555_0000));
        req_vld = 8'h20;
        tick();
        req_vld = '0;
        chk("b5_overlap", 64'(err_overlap), 64'h20);
        idle(2);
        chk("b5_one_hdr", 64'(hdr_seen[5]), 64'd1);
        send(8'h20, put(5, 32'h0000_0056), put(5, 32'h6666_0000));
        chk("b5_second_hdr_vld", 64'(hdr_vld), 64'h20);
        idle(3);
        chk("b5_two_hdrs", 64'(hdr_seen[5]), 64'd2);
        chk("b5_iq", 64'(iq_of(5)), 64'd2);

        // Bank 7: underflow, then fill the IQ to its depth and one past it.
        // Word 0 has bit 29 set, so the WIB count saturates silently at 8.
        iq_dq = 8'h80;
        tick();
        iq_dq = '0;
        chk("b7_uflow", 64'(err_iq_uflow), 64'h80);
        chk("b7_iq_zero", 64'(iq_of(7)), 64'd0);
        for (int i = 0; i < 16; i++) begin
            send(8'h80, put(7, 32'h7000_0000 | 32'(i)), put(7, 32'h0000_7700 | 32'(i)));
            idle(3);
        end
        chk("b7_iq_full", 64'(iq_of(7)), 64'd16);
        chk("b7_no_oflow_yet", 64'(err_iq_oflow), 64'h00);
        send(8'h80, put(7, 32'h7000_0010), put(7, 32'h0000_7710));
        idle(3);
        chk("b7_iq_sat", 64'(iq_of(7)), 64'd16);
        chk("b7_oflow", 64'(err_iq_oflow), 64'h80);
        chk("b7_wib_sat", 64'(wib_of(7)), 64'd8);
        chk("b7_no_wib_err", 64'(err_wib_uflow), 64'h00);

        // All banks at once; bank 5 dequeues in the same cycle as its pulse
        for (int b = 0; b < NB; b++) begin
            w0v[b*RW +: RW] = 32'hC000_0000 | 32'(b << 8);
            w1v[b*RW +: RW] = 32'h0BAD_0000 | 32'(b);
        end
        send(8'hFF, w0v, w1v);
        chk("all_hdr_vld", 64'(hdr_vld), 64'hFF);
        iq_dq = 8'h20;
        tick();
        iq_dq = '0;
        chk("all_b5_iq_hold", 64'(iq_of(5)), 64'd2);
        chk("all_b0_iq", 64'(iq_of(0)), 64'd2);
        chk("all_b3_iq", 64'(iq_of(3)), 64'd1);
        idle(2);

        // WIB underflow on bank 6
        wib_dq = 8'h40;
        tick();
        wib_dq = '0;
        chk("b6_wib_uflow", 64'(err_wib_uflow), 64'h40);
        chk("b6_wib_zero", 64'(wib_of(6)), 64'd0);

        // mon_en drops while bank 1 is mid-header: the sequence still ends
        exp_q.push_back('{1, {32'h1111_0002, 32'h1111_0001}});
        req_vld = 8'h02;
        tick();
        req_vld = '0; mon_en = 1'b0;
        req = put(1, 32'h1111_0001);
        tick();
        req = put(1, 32'h1111_0002);
        tick();
        req = '0;
        chk("en_off_hdr_vld", 64'(hdr_vld), 64'h02);
        idle(3);
        chk("en_off_b1_iq", 64'(iq_of(1)), 64'd2);
        // With tracking off a new request is ignored and errors stay clear
        send(8'h04, put(2, 32'h2222_0001), put(2, 32'h2222_0002));
        idle(3);
        chk("en_off_b2_ignored", 64'(hdr_seen[2]), 64'd1);
        iq_dq = 8'h08;
        tick();
        tick();
        iq_dq = '0;
        chk("en_off_b3_iq", 64'(iq_of(3)), 64'd0);
        chk("en_off_no_uflow", 64'(err_iq_uflow), 64'h80);
        chk("en_off_no_overlap", 64'(err_overlap), 64'h20);
        mon_en = 1'b1;

        // Reset two cycles into a bank 4 request
        req_vld = 8'h10;
        tick();
        req_vld = '0;
        req = put(4, 32'h4444_0001);
        tick();
        req = put(4, 32'h4444_0002);
        rst = 1'b1;
        tick();
        rst = 1'b0; req = '0;
        chk("mid_rst_hdr_vld", 64'(hdr_vld), 64'd0);
        chk("mid_rst_hdr_data", 64'(|hdr_data), 64'd0);
        chk("mid_rst_iq", 64'(iq_cnt), 64'd0);
        chk("mid_rst_wib", 64'(wib_cnt), 64'd0);
        chk("mid_rst_errs", 64'({err_overlap, err_iq_uflow, err_iq_oflow, err_wib_uflow}), 64'd0);
        idle(4);
        chk("mid_rst_no_b4_hdr", 64'(hdr_seen[4]), 64'd1);

`ifdef SIU_L2_TRK_STATS_EN
        // Three headers on bank 0, one of them a WRI
        send(8'h01, put(0, 32'h2000_0A01), put(0, 32'h0000_0001));
        idle(3);
        send(8'h01, put(0, 32'h8000_0A02), put(0, 32'h0000_0002));
        idle(3);
        send(8'h01, put(0, 32'h8000_0A03), put(0, 32'h0000_0003));
        idle(3);
        chk("stats_req_total", 64'(req_total[15:0]), 64'd3);
        chk("stats_wri_total", 64'(wri_total[15:0]), 64'd1);
        chk("stats_b1_zero", 64'(req_total[31:16]), 64'd0);
`endif

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
